// File: rtl/bbs_bit_packer.sv
// bbs_bit_packer: packs the BBS serial bit stream (optionally von Neumann debiased) into words behind a show-ahead valid/ready FIFO
//   in_bit/in_valid  : one generator bit per valid cycle
//   flush            : emit the partial word left-justified and zero-padded
//   out_word/out_valid/out_ready : FIFO head word and handshake
//   level/drop_cnt/busy : occupancy, saturating dropped-word count, partial data held
module bbs_bit_packer #(
    parameter int OUT_W  = 16,
    parameter int DEPTH  = 4,
    parameter bit DEBIAS = 0,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_bit,
    input  logic                    in_valid,
    input  logic                    flush,
    output logic [OUT_W-1:0]        out_word,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic [CNT_W-1:0]        drop_cnt,
    output logic                    busy
);
    localparam int CW = $clog2(OUT_W + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = DEPTH[PW:0];
    logic [OUT_W-1:0] sr, sr_n, word;
    logic [CW-1:0] cnt, cnt_n;
    logic pair_full, pair_bit, acc, acc_bit, push, pop, wr, drop;
    logic [OUT_W-1:0] mem [DEPTH];
    logic [PW-1:0] wp, rp;
    // A word completes when cnt_n reaches OUT_W (shift of 0); a flush
    // left-justifies the n live low bits, pushing stale upper bits out.
    always_comb begin
        acc     = DEBIAS ? in_valid && pair_full && pair_bit != in_bit : in_valid;
        acc_bit = DEBIAS ? pair_bit : in_bit;
        sr_n    = acc ? {sr[OUT_W-2:0], acc_bit} : sr;
        cnt_n   = cnt + CW'(acc);
        word    = sr_n << (CW'(OUT_W) - cnt_n);
        push    = cnt_n == CW'(OUT_W) || (flush && cnt_n != '0);
        pop     = out_valid && out_ready;
        wr      = push && (level != FULL || pop);
        drop    = push && !wr;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sr        <= '0;
            cnt       <= '0;
            pair_full <= 1'b0;
            pair_bit  <= 1'b0;
            wp        <= '0;
            rp        <= '0;
            level     <= '0;
            drop_cnt  <= '0;
        end else begin
            sr        <= sr_n;
            cnt       <= push ? '0 : cnt_n;
            pair_full <= flush ? 1'b0 : pair_full ^ (DEBIAS && in_valid);
            pair_bit  <= in_valid && !pair_full ? in_bit : pair_bit;
            wp        <= wp + PW'(wr);
            rp        <= rp + PW'(pop);
            level     <= level + (PW+1)'(wr) - (PW+1)'(pop);
            drop_cnt  <= drop && !(&drop_cnt) ? drop_cnt + CNT_W'(1) : drop_cnt;
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= word;
    end
    assign out_valid = level != '0;
    assign out_word  = out_valid ? mem[rp] : '0;
    assign busy      = cnt != '0 || pair_full;
endmodule

// File: doc/bbs_bit_packer.md
Name: bbs_bit_packer

Overview:
- Downstream stage of the BBS generator: consumes its serial output bit stream (out_bit qualified by out_valid) and packs it into OUT_W-bit words.
- Optional von Neumann debiasing stage in front of the packer.
- Show-ahead word FIFO with a valid/ready output handshake, so a bus or host consumer can apply backpressure.
- The generator cannot stall, so words that arrive while the FIFO is full are dropped and counted.

Parameters:
- OUT_W, 16: packed word width in bits; must be >= 2.
- DEPTH, 4: word FIFO depth; power of 2, >= 2.
- DEBIAS, 0: 1 enables the von Neumann pair filter; 0 passes every input bit through.
- CNT_W, 8: width of the saturating dropped-word counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- in_bit  input  1  random bit from the generator.
- in_valid  input  1  in_bit is valid this cycle; each high cycle is exactly one bit.
- flush  input  1  emit the partial word, left-justified and zero-padded.
- out_word  output  OUT_W  FIFO head word; 0 when out_valid=0.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_word this cycle.
- level  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- drop_cnt  output  CNT_W  count of words dropped on a full FIFO; saturating.
- busy  output  1  partial word or half-pair held: bit_cnt != 0 or pair_full.

Behaviour:
Clocking and reset:
- Single clock domain.
- On the edge where reset=1, all state clears regardless of other inputs: shift register, bit_cnt, pair_full, FIFO pointers, drop_cnt.
- Reset outputs: out_word=0, out_valid=0, level=0, drop_cnt=0, busy=0.
- Reset mid-word or mid-drain discards all held data.

Bit acceptance:
- DEBIAS=0: every in_valid=1 cycle yields one accepted bit.
- DEBIAS=1:
  - First bit of a pair is stored and pair_full is set.
  - Second bit: pair (a,b) with a!=b yields accepted bit a (pair 1,0 gives 1; pair 0,1 gives 0).
  - Pair with a==b is discarded.
  - pair_full clears in both cases.

Packing:
- Accepted bit shifts into the LSB, existing bits shift left.
- The first bit of a word therefore ends at bit OUT_W-1.
- bit_cnt counts accepted bits, 0..OUT_W-1.

Word completion:
- Triggered on the edge where the OUT_W-th bit is accepted.
- The full word is pushed to the FIFO if level<DEPTH, or if level==DEPTH and a pop happens on the same edge.
- Otherwise the word is dropped and drop_cnt increments, saturating at 2^CNT_W-1.
- bit_cnt returns to 0 in both cases.

Flush (sampled at posedge):
- The accepted bit of the same cycle, if any, is included first.
- If that bit completes a word, normal completion applies.
- Else if bit_cnt after inclusion is n>0:
  - The word is the n bits left-justified (shifted left by OUT_W-n), low bits zero.
  - It is pushed under the same full/drop rules, and bit_cnt clears.
- If n=0, nothing is pushed.
- Flush always clears pair_full; a pending half-pair is discarded.

FIFO:
- Show-ahead: out_word is the head entry whenever out_valid=1.
- Pop occurs when out_valid && out_ready.
- Push and pop on the same edge leave level unchanged; this is legal when full.
- Pointers wrap modulo DEPTH.

Latency:
- Completing bit or flush accepted at edge k with the FIFO empty gives out_valid=1 and the word on out_word after edge k, i.e. in cycle k+1.
- Throughput: at most one word push and one pop per cycle.

Test Plan:
1. DEBIAS=0, out_ready=1: 16 consecutive bits 1,0,1,0,... -> out_valid high exactly one cycle after the 16th bit's edge, out_word=16'hAAAA, then level=0, busy=0.
2. out_ready=0: feed 80 one-bits -> level=4, 5th word dropped, drop_cnt=1. Then out_ready=1 -> four words of 16'hFFFF on consecutive cycles, level back to 0.
3. Bits 1,1,0,1,1, then flush with in_valid=0 -> out_word=16'hD800, busy=0 after the flush edge. Flush with bit_cnt=0 -> no push.
4. DEBIAS=1: pairs (1,0),(0,1) repeated 8 times (32 input bits, in_valid gaps inserted) -> one word 16'hAAAA. Pairs (1,1),(0,0) -> no accepted bits, busy toggles with pair_full only.
5. Seven bits accepted, then reset pulse -> level=0, busy=0, out_valid=0. Next 16 bits of all zeros -> out_word=16'h0000 with out_valid=1, with no stale bits.
6. CNT_W=2, FIFO full, out_ready=0: complete 5 extra words -> drop_cnt saturates at 3. Full FIFO with out_ready=1 on the completing edge -> push accepted, level stays 4, drop_cnt unchanged.
